// File: rtl/memory_pkg.sv
// Shared encodings for the memory subsystem: access kind, arbiter FSM states,
// port identifiers and busy-counter width.
package memory_pkg;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } access_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_0 = 2'd1,
        ST_BUSY_1 = 2'd2
    } arb_state_e;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_LSU    = 1'b1;

    localparam int BUSY_CNT_W = 16;

endpackage

// File: rtl/memory_arbiter_priority.sv
// Grant decision between the instruction-fetch and load/store ports.
// ROUND_ROBIN_EN: on contention pick the port not granted last; otherwise load/store wins.
module arbiter_priority
    import memory_pkg::*;
(
    input  logic i_req_0,
    input  logic i_req_1,
    input  logic i_last_grant,
    output logic o_winner
);

`ifdef ROUND_ROBIN_EN
    always_comb begin
        if (i_req_0 && i_req_1) begin
            o_winner = ~i_last_grant;
        end else begin
            o_winner = i_req_1 ? PORT_LSU : PORT_IFETCH;
        end
    end
`else
    // Fixed priority only needs to know whether load/store is asking.
    logic w_unused_inputs;
    assign w_unused_inputs = i_req_0 | i_last_grant;
    assign o_winner        = i_req_1 ? PORT_LSU : PORT_IFETCH;
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Two-port memory arbiter: registers the winning port's request onto the memory
// bus, waits for mem_done or a busy timeout. Optional ROUND_ROBIN_EN fairness.
module memory_arbiter
    import memory_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_0,
    input  logic        i_req_1,
    input  logic        i_state_0,
    input  logic        i_state_1,
    input  logic [3:0]  i_mask_0,
    input  logic [3:0]  i_mask_1,
    input  logic [31:0] i_address_0,
    input  logic [31:0] i_address_1,
    input  logic [31:0] i_wdata_0,
    input  logic [31:0] i_wdata_1,
    output logic        o_grant_0,
    output logic        o_grant_1,
    output logic        o_done_0,
    output logic        o_done_1,
    output logic [31:0] o_rdata_0,
    output logic [31:0] o_rdata_1,
    output logic        o_mem_enable,
    output logic        o_mem_state,
    output logic [3:0]  o_mem_frame_mask,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_done,
    output logic        o_timeout_error
);

    localparam logic [BUSY_CNT_W-1:0] TIMEOUT_LAST = BUSY_CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e            r_state;
    arb_state_e            w_next_state;
    logic                  w_winner;
    logic                  w_last_grant;
    logic                  w_start;
    logic                  w_complete;
    logic                  w_abort;
    logic                  w_timeout;
    logic                  w_busy_1;
    logic [BUSY_CNT_W-1:0] r_count;
    logic                  r_mem_enable;
    access_e               r_mem_state;
    logic [3:0]            r_mem_frame_mask;
    logic [31:0]           r_mem_address;
    logic [31:0]           r_mem_wdata;
    logic                  r_grant_0;
    logic                  r_grant_1;
    logic                  r_done_0;
    logic                  r_done_1;
    logic [31:0]           r_rdata_0;
    logic [31:0]           r_rdata_1;
    logic                  r_timeout_error;

    arbiter_priority u_priority (
        .i_req_0      (i_req_0),
        .i_req_1      (i_req_1),
        .i_last_grant (w_last_grant),
        .o_winner     (w_winner)
    );

`ifdef ROUND_ROBIN_EN
    logic r_last_grant;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= PORT_IFETCH;
        end else if (w_start) begin
            r_last_grant <= w_winner;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = PORT_IFETCH;
`endif

    assign w_start   = (r_state == ST_IDLE) && (i_req_0 || i_req_1);
    assign w_busy_1  = (r_state == ST_BUSY_1);
    assign w_timeout = (r_count == TIMEOUT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // mem_done wins over a timeout landing on the same edge.
    always_comb begin
        w_next_state = r_state;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = w_winner ? ST_BUSY_1 : ST_BUSY_0;
                end
            end
            ST_BUSY_0, ST_BUSY_1: begin
                if (i_mem_done) begin
                    w_complete   = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_enable     <= 1'b0;
            r_mem_state      <= ACC_READ;
            r_mem_frame_mask <= '0;
            r_mem_address    <= '0;
            r_mem_wdata      <= '0;
            r_grant_0        <= 1'b0;
            r_grant_1        <= 1'b0;
            r_done_0         <= 1'b0;
            r_done_1         <= 1'b0;
            r_rdata_0        <= '0;
            r_rdata_1        <= '0;
            r_count          <= '0;
            r_timeout_error  <= 1'b0;
        end else begin
            r_done_0 <= 1'b0;
            r_done_1 <= 1'b0;
            if (w_start) begin
                r_mem_enable     <= 1'b1;
                r_mem_state      <= access_e'(w_winner ? i_state_1 : i_state_0);
                r_mem_frame_mask <= w_winner ? i_mask_1 : i_mask_0;
                r_mem_address    <= w_winner ? i_address_1 : i_address_0;
                r_mem_wdata      <= w_winner ? i_wdata_1 : i_wdata_0;
                r_grant_0        <= ~w_winner;
                r_grant_1        <= w_winner;
                r_count          <= '0;
            end else if (w_complete || w_abort) begin
                r_mem_enable <= 1'b0;
                r_grant_0    <= 1'b0;
                r_grant_1    <= 1'b0;
                if (w_busy_1) begin
                    r_done_1 <= 1'b1;
                end else begin
                    r_done_0 <= 1'b1;
                end
                if (w_complete && (r_mem_state == ACC_READ)) begin
                    if (w_busy_1) begin
                        r_rdata_1 <= i_mem_rdata;
                    end else begin
                        r_rdata_0 <= i_mem_rdata;
                    end
                end
                if (w_abort) begin
                    r_timeout_error <= 1'b1;
                end
            end else if (r_state != ST_IDLE) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign o_grant_0        = r_grant_0;
    assign o_grant_1        = r_grant_1;
    assign o_done_0         = r_done_0;
    assign o_done_1         = r_done_1;
    assign o_rdata_0        = r_rdata_0;
    assign o_rdata_1        = r_rdata_1;
    assign o_mem_enable     = r_mem_enable;
    assign o_mem_state      = r_mem_state;
    assign o_mem_frame_mask = r_mem_frame_mask;
    assign o_mem_address    = r_mem_address;
    assign o_mem_wdata      = r_mem_wdata;
    assign o_timeout_error  = r_timeout_error;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max busy cycles before abort (legal range 1..65535).
REQ-002 SHALL have ports: CLK  input  1  clock, all state on rising edge.
REQ-003 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have: req_0 / req_1  input  1  transaction request (port 0 = instruction fetch, port 1 = load/store).
REQ-005 SHALL have: state_0 / state_1  input  1  access kind, READ or WRITE encoding from shared package.
REQ-006 SHALL have: mask_0 / mask_1  input  4  byte-lane frame mask.
REQ-007 SHALL have: address_0 / address_1  input  32  byte address.
REQ-008 SHALL have: wdata_0 / wdata_1  input  32  store data.
REQ-009 SHALL have: grant_0 / grant_1  output  1  port owns memory.
REQ-010 SHALL have: done_0 / done_1  output  1  one-cycle completion pulse.
REQ-011 SHALL have: rdata_0 / rdata_1  output  32  captured read data.
REQ-012 SHALL have: mem_enable  output  1; mem_state  output  1; mem_frame_mask  output  4; mem_address  output  32; mem_wdata  output  32 -- memory-side request.
REQ-013 SHALL have: mem_rdata  input  32; mem_done  input  1 -- memory-side response.
REQ-014 SHALL have: timeout_error  output  1  sticky abort flag.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY_0, BUSY_1.
REQ-016 In IDLE, SHALL sample req_0/req_1 each edge; any request moves to BUSY_x on the next edge.
REQ-017 On entering BUSY_x, SHALL register state/mask/address/wdata of port x onto mem_* outputs and assert grant_x and mem_enable; outputs hold stable for the whole transaction.
REQ-018 Latency: request sampled at edge N -> mem_enable high after edge N+1.
REQ-019 In BUSY_x, mem_done sampled high SHALL: pulse done_x for one cycle, capture mem_rdata into rdata_x (READ only; WRITE leaves rdata_x unchanged), drop grant_x/mem_enable, return to IDLE.
REQ-020 Back-to-back transactions SHALL incur exactly one IDLE cycle between them.
REQ-021 Deassertion of req_x during BUSY_x SHALL be ignored; transaction completes normally.
REQ-022 Requesters SHALL hold req_x until done_x; rdata_x holds until next completed read on that port.
REQ-023 Simultaneous req_0 and req_1 in IDLE SHALL resolve per REQ-030/031; loser stays pending, no request lost.
REQ-024 16-bit busy counter SHALL clear on entering BUSY_x, increment each BUSY cycle; reaching TIMEOUT_CYCLES without mem_done SHALL abort: done_x pulse, rdata_x unchanged, timeout_error set, return to IDLE.
REQ-025 mem_done and timeout in same cycle SHALL be treated as normal completion, no error.
REQ-026 mem_done in IDLE SHALL be ignored.

Reset
REQ-027 reset low SHALL immediately force IDLE; grant_x, done_x, mem_enable, timeout_error = 0; mem_state = READ; mem_frame_mask = 0; mem_address, mem_wdata, rdata_x = 0; counter = 0; last-grant = port 0.
REQ-028 Reset mid-transaction SHALL abort without done pulse; memory sees mem_enable drop.
REQ-029 timeout_error SHALL clear only on reset.

Configuration
REQ-030 With ROUND_ROBIN_EN defined, contention SHALL grant the port not granted last; last-grant register updates on every grant.
REQ-031 Without ROUND_ROBIN_EN, contention SHALL always grant port 1 (load/store); no last-grant register.

Structure
REQ-032 READ/WRITE encoding and FSM state constants SHALL live in shared package memory_pkg, reused by the memory interface and load/store unit.
REQ-033 Grant decision SHALL be a sub-module arbiter_priority (inputs: req_0, req_1, last-grant; output: winner); all else in memory_arbiter.

Verification
REQ-034 Single read: req_1, READ, address 0x100, mask 1111; mem_done after 3 cycles with mem_rdata 0xDEADBEEF -> rdata_1 = 0xDEADBEEF, done_1 one pulse, mem_enable 4 cycles.
REQ-035 Write: req_0, WRITE, address 0x4, wdata 0x12345678, mask 0011 -> mem_* match exactly, rdata_0 unchanged.
REQ-036 Contention: both requesting continuously, 4 transactions -> with ROUND_ROBIN_EN grants 1,0,1,0; without, port 1 only while req_1 held.
REQ-037 Timeout: TIMEOUT_CYCLES = 8, mem_done never -> done_x after 8 busy cycles, timeout_error = 1, remains 1 until reset.
REQ-038 Reset mid-BUSY: reset low 2 cycles after grant -> all outputs zero asynchronously, no done pulse, fresh request after release served normally.
